// File: rtl/nco_ctrl_pkg.sv
// Shared types and default parameters for the multi-channel NCO controller.
// Contents:
//   state_t      - 2-bit controller state encoding, also exposed as state_o
//   *_DEF        - default parameter values used by the controller modules
package nco_ctrl_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_WAIT = 2'd3
    } state_t;

    localparam int NUM_CH_DEF = 4;
    localparam int FREQ_W_DEF = 14;
    localparam int LUT_AW_DEF = 10;
    localparam int DATA_W_DEF = 12;

endpackage

// File: rtl/lut_load_ctr.sv
// LUT load address counter with terminal-count detect and registered write bus.
// Ports:
//   clk, rst_n          - clock, asynchronous active-low reset
//   clr                 - clear the address counter to 0
//   inc                 - accept one sample: register a write and advance
//   data                - sample to write on an accepted transfer
//   addr                - current address counter value
//   last                - counter sits at the final LUT address
//   we, wr_addr, wr_data - registered LUT write strobe, address and data
module lut_load_ctr
    import nco_ctrl_pkg::*;
#(
    parameter int LUT_AW = LUT_AW_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              inc,
    input  logic [DATA_W-1:0] data,
    output logic [LUT_AW-1:0] addr,
    output logic              last,
    output logic              we,
    output logic [LUT_AW-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data
);

    assign last = &addr;

    // NOTE: sequential state is assigned with <= so every flop samples
    // pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr <= '0;
        end else if (clr) begin
            addr <= '0;
        end else if (inc) begin
            // Wraps to 0 naturally after the final address.
            addr <= addr + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we      <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
        end else begin
            we <= inc;
            if (inc) begin
                wr_addr <= addr;
                wr_data <= data;
            end
        end
    end

endmodule

// File: rtl/nco_multi_ctrl.sv
// Control FSM for the multi-channel waveform generator: streams samples into
// the shared LUT, starts/stops a masked group of NCO channels and gates each
// channel enable on a non-zero frequency step. All outputs are registered.
// Ports:
//   run_start_i/run_stop_i/ch_mask_i - channel group start, stop (or load abort)
//   load_start_i, load_valid_i/load_data_i/load_ready_o - LUT sample stream
//   freq_step_i                      - per-channel steps, ch i at [i*FREQ_W +: FREQ_W]
//   lut_we_o/lut_addr_o/lut_data_o   - LUT write port
//   nco_en_o, nco_freq_o             - per-channel enables and registered steps
//   load_done_o                      - pulse after the last LUT word is written
//   busy_o, state_o                  - status readback
module nco_multi_ctrl
    import nco_ctrl_pkg::*;
#(
    parameter int NUM_CH = NUM_CH_DEF,
    parameter int FREQ_W = FREQ_W_DEF,
    parameter int LUT_AW = LUT_AW_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     run_start_i,
    input  logic                     run_stop_i,
    input  logic [NUM_CH-1:0]        ch_mask_i,
    input  logic                     load_start_i,
    input  logic                     load_valid_i,
    input  logic [DATA_W-1:0]        load_data_i,
    output logic                     load_ready_o,
    input  logic [NUM_CH*FREQ_W-1:0] freq_step_i,
    output logic                     lut_we_o,
    output logic [LUT_AW-1:0]        lut_addr_o,
    output logic [DATA_W-1:0]        lut_data_o,
    output logic [NUM_CH-1:0]        nco_en_o,
    output logic [NUM_CH*FREQ_W-1:0] nco_freq_o,
    output logic                     load_done_o,
    output logic                     busy_o,
    output logic [1:0]               state_o
);

    state_t            state, state_next;
    logic [NUM_CH-1:0] active_mask;
    logic [NUM_CH-1:0] step_nz;
    logic              any_active;
    logic              ctr_clr, ctr_inc, ctr_last;
    logic              mask_load, mask_clr;
    logic [LUT_AW-1:0] ctr_addr;

    // Per-channel zero-detect, OR-reduced over the masked channels.
    always_comb begin
        step_nz = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            step_nz[i] = |freq_step_i[i*FREQ_W +: FREQ_W];
        end
    end

    assign any_active = |(active_mask & step_nz);

    // NOTE: every variable gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        ctr_clr    = 1'b0;
        ctr_inc    = 1'b0;
        mask_load  = 1'b0;
        mask_clr   = 1'b0;
        case (state)
            S_IDLE: begin
                // Stop outranks everything; load outranks run start.
                if (run_stop_i) begin
                    state_next = S_IDLE;
                end else if (load_start_i) begin
                    state_next = S_LOAD;
                    ctr_clr    = 1'b1;
                end else if (run_start_i && (|ch_mask_i)) begin
                    state_next = S_RUN;
                    mask_load  = 1'b1;
                end
            end
            S_LOAD: begin
                if (run_stop_i) begin
                    // Abort: no write this cycle, restart at address 0 next time.
                    state_next = S_IDLE;
                    ctr_clr    = 1'b1;
                end else if (load_valid_i) begin
                    ctr_inc = 1'b1;
                    if (ctr_last) begin
                        state_next = S_IDLE;
                    end
                end
            end
            S_RUN: begin
                if (run_stop_i) begin
                    state_next = S_IDLE;
                    mask_clr   = 1'b1;
                end else begin
                    if (run_start_i && (|ch_mask_i)) begin
                        mask_load = 1'b1;
                    end
                    if (!any_active) begin
                        state_next = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (run_stop_i) begin
                    state_next = S_IDLE;
                    mask_clr   = 1'b1;
                end else if (any_active) begin
                    state_next = S_RUN;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            active_mask  <= '0;
            nco_en_o     <= '0;
            nco_freq_o   <= '0;
            load_done_o  <= 1'b0;
            load_ready_o <= 1'b0;
        end else begin
            state <= state_next;
            if (mask_clr) begin
                active_mask <= '0;
            end else if (mask_load) begin
                active_mask <= ch_mask_i;
            end
            // Enable follows the state being entered, using the mask latched
            // on an earlier edge; a freshly latched mask shows one cycle later.
            nco_en_o <= (state_next == S_RUN) ? (active_mask & step_nz) : '0;
            if (state == S_RUN || state == S_WAIT) begin
                nco_freq_o <= freq_step_i;
            end
            load_done_o  <= ctr_inc && ctr_last;
            load_ready_o <= (state_next == S_LOAD);
        end
    end

    assign busy_o  = (state != S_IDLE);
    assign state_o = state;

    lut_load_ctr #(
        .LUT_AW(LUT_AW),
        .DATA_W(DATA_W)
    ) u_ctr (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (ctr_clr),
        .inc     (ctr_inc),
        .data    (load_data_i),
        .addr    (ctr_addr),
        .last    (ctr_last),
        .we      (lut_we_o),
        .wr_addr (lut_addr_o),
        .wr_data (lut_data_o)
    );

endmodule

// File: tb/tb_nco_multi_ctrl.sv
// Self-checking bench for nco_multi_ctrl (NUM_CH=4, FREQ_W=14, LUT_AW=4,
// DATA_W=12): LUT load sequences, run/wait gating vectors and async reset.
module tb_nco_multi_ctrl;

    localparam int NUM_CH = 4;
    localparam int FREQ_W = 14;
    localparam int LUT_AW = 4;
    localparam int DATA_W = 12;

    // Step sets, ch3..ch0.
    localparam logic [55:0] F0 = {14'd0, 14'd0, 14'd100, 14'd25};
    localparam logic [55:0] F1 = {14'd0, 14'd0, 14'd100, 14'd0};
    localparam logic [55:0] F2 = {14'd0, 14'd7, 14'd100, 14'd0};

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic                     run_start, run_stop, load_start, load_valid;
    logic [NUM_CH-1:0]        ch_mask;
    logic [DATA_W-1:0]        load_data;
    logic [NUM_CH*FREQ_W-1:0] freq_step;
    logic                     load_ready, lut_we, load_done, busy;
    logic [LUT_AW-1:0]        lut_addr;
    logic [DATA_W-1:0]        lut_data;
    logic [NUM_CH-1:0]        nco_en;
    logic [NUM_CH*FREQ_W-1:0] nco_freq;
    logic [1:0]               state;

    int n_checks = 0;
    int n_fail   = 0;
    int wr_count;

    typedef struct {
        logic        run_start;
        logic        run_stop;
        logic        load_start;
        logic [3:0]  mask;
        logic [55:0] freq;
        logic [1:0]  exp_state;
        logic [3:0]  exp_en;
        logic [55:0] exp_freq;
    } vec_t;

    vec_t vecs[12];

    always #5 clk = ~clk;

    nco_multi_ctrl #(
        .NUM_CH(NUM_CH),
        .FREQ_W(FREQ_W),
        .LUT_AW(LUT_AW),
        .DATA_W(DATA_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .run_start_i  (run_start),
        .run_stop_i   (run_stop),
        .ch_mask_i    (ch_mask),
        .load_start_i (load_start),
        .load_valid_i (load_valid),
        .load_data_i  (load_data),
        .load_ready_o (load_ready),
        .freq_step_i  (freq_step),
        .lut_we_o     (lut_we),
        .lut_addr_o   (lut_addr),
        .lut_data_o   (lut_data),
        .nco_en_o     (nco_en),
        .nco_freq_o   (nco_freq),
        .load_done_o  (load_done),
        .busy_o       (busy),
        .state_o      (state)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Advance one edge; outputs are sampled 1 ns after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_pulses();
        run_start  = 1'b0;
        run_stop   = 1'b0;
        load_start = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " lut_we"},     64'(lut_we),     64'd0);
        check({tag, " lut_addr"},   64'(lut_addr),   64'd0);
        check({tag, " lut_data"},   64'(lut_data),   64'd0);
        check({tag, " load_done"},  64'(load_done),  64'd0);
        check({tag, " load_ready"}, 64'(load_ready), 64'd0);
        check({tag, " busy"},       64'(busy),       64'd0);
        check({tag, " state"},      64'(state),      64'd0);
        check({tag, " nco_en"},     64'(nco_en),     64'd0);
        check({tag, " nco_freq"},   64'(nco_freq),   64'd0);
    endtask

    initial begin
        rst_n      = 1'b0;
        ch_mask    = '0;
        load_valid = 1'b0;
        load_data  = '0;
        freq_step  = '0;
        clear_pulses();

        // Run/wait vectors, applied from S_IDLE; expectations after the edge.
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 4'b0101, F0, 2'd2, 4'b0000, 56'd0};
        vecs[1]  = '{1'b0, 1'b0, 1'b0, 4'b0000, F0, 2'd2, 4'b0001, F0};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 4'b0000, F0, 2'd2, 4'b0001, F0};
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 4'b0000, F1, 2'd3, 4'b0000, F1};
        vecs[4]  = '{1'b0, 1'b0, 1'b0, 4'b0000, F1, 2'd3, 4'b0000, F1};
        vecs[5]  = '{1'b0, 1'b0, 1'b0, 4'b0000, F2, 2'd2, 4'b0100, F2};
        vecs[6]  = '{1'b1, 1'b0, 1'b0, 4'b0010, F2, 2'd2, 4'b0100, F2};
        vecs[7]  = '{1'b0, 1'b0, 1'b0, 4'b0000, F2, 2'd2, 4'b0010, F2};
        vecs[8]  = '{1'b1, 1'b0, 1'b0, 4'b0000, F2, 2'd2, 4'b0010, F2};
        vecs[9]  = '{1'b0, 1'b1, 1'b1, 4'b0000, F2, 2'd0, 4'b0000, F2};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 4'b0000, F2, 2'd0, 4'b0000, F2};
        vecs[11] = '{1'b1, 1'b0, 1'b0, 4'b0000, F2, 2'd0, 4'b0000, F2};

        #17;
        check_all_zero("reset");
        rst_n = 1'b1;
        step();

        // Full load, continuous valid, data = address*3.
        load_start = 1'b1;
        step();
        clear_pulses();
        check("load state", 64'(state), 64'd1);
        check("load ready", 64'(load_ready), 64'd1);
        check("load busy", 64'(busy), 64'd1);
        for (int k = 0; k < 16; k++) begin
            load_valid = 1'b1;
            load_data  = 12'(k * 3);
            step();
            check($sformatf("full we[%0d]", k),   64'(lut_we),   64'd1);
            check($sformatf("full addr[%0d]", k), 64'(lut_addr), 64'(k));
            check($sformatf("full data[%0d]", k), 64'(lut_data), 64'(k * 3));
            check($sformatf("full done[%0d]", k), 64'(load_done), (k == 15) ? 64'd1 : 64'd0);
            check($sformatf("full busy[%0d]", k), 64'(busy),      (k == 15) ? 64'd0 : 64'd1);
        end
        load_valid = 1'b0;
        check("full end state", 64'(state), 64'd0);
        step();
        check("done one pulse", 64'(load_done), 64'd0);
        check("we after load", 64'(lut_we), 64'd0);

        // Valid toggling every other cycle, then abort after 5 transfers.
        wr_count   = 0;
        load_start = 1'b1;
        step();
        clear_pulses();
        for (int t = 0; t < 10; t++) begin
            load_valid = (t % 2 == 0);
            load_data  = 12'(200 + t);
            step();
            wr_count += int'(lut_we);
            if (t % 2 == 0) begin
                check($sformatf("tog addr[%0d]", t), 64'(lut_addr), 64'(t / 2));
                check($sformatf("tog data[%0d]", t), 64'(lut_data), 64'(200 + t));
            end else begin
                check($sformatf("tog idle we[%0d]", t), 64'(lut_we), 64'd0);
            end
        end
        run_stop   = 1'b1;
        load_valid = 1'b1;
        step();
        clear_pulses();
        load_valid = 1'b0;
        wr_count += int'(lut_we);
        check("abort state", 64'(state), 64'd0);
        check("abort no done", 64'(load_done), 64'd0);
        check("abort write count", 64'(wr_count), 64'd5);

        // Fresh load starts at address 0; reset strikes at address 9.
        load_start = 1'b1;
        step();
        clear_pulses();
        for (int k = 0; k < 10; k++) begin
            load_valid = 1'b1;
            load_data  = 12'(50 + k);
            step();
            check($sformatf("reload addr[%0d]", k), 64'(lut_addr), 64'(k));
        end
        check("reload data@9", 64'(lut_data), 64'd59);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("load rst");
        load_valid = 1'b0;
        #1;
        rst_n = 1'b1;
        step();
        check("post rst state", 64'(state), 64'd0);
        load_start = 1'b1;
        step();
        clear_pulses();
        load_valid = 1'b1;
        load_data  = 12'd7;
        step();
        load_valid = 1'b0;
        check("post rst addr", 64'(lut_addr), 64'd0);
        check("post rst we", 64'(lut_we), 64'd1);
        run_stop = 1'b1;
        step();
        clear_pulses();

        // Run/wait table.
        for (int v = 0; v < 12; v++) begin
            run_start  = vecs[v].run_start;
            run_stop   = vecs[v].run_stop;
            load_start = vecs[v].load_start;
            ch_mask    = vecs[v].mask;
            freq_step  = vecs[v].freq;
            step();
            clear_pulses();
            check($sformatf("vec%0d state", v), 64'(state),    64'(vecs[v].exp_state));
            check($sformatf("vec%0d en", v),    64'(nco_en),   64'(vecs[v].exp_en));
            check($sformatf("vec%0d freq", v),  64'(nco_freq), 64'(vecs[v].exp_freq));
        end

        // Load and run start together: load wins, mask not latched.
        load_start = 1'b1;
        run_start  = 1'b1;
        ch_mask    = 4'b1111;
        step();
        clear_pulses();
        check("both state", 64'(state), 64'd1);
        check("both mask", 64'(dut.active_mask), 64'd0);
        run_stop = 1'b1;
        step();
        clear_pulses();
        check("both stop state", 64'(state), 64'd0);

        // Mid-run asynchronous reset.
        run_start = 1'b1;
        ch_mask   = 4'b0001;
        freq_step = F0;
        step();
        clear_pulses();
        step();
        check("run en", 64'(nco_en), 64'd1);
        check("run freq", 64'(nco_freq), 64'(F0));
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("run rst");
        #1;
        rst_n = 1'b1;
        step();
        check("run rst state", 64'(state), 64'd0);
        check("run rst en", 64'(nco_en), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
